// File: rtl/rvh_noc_pkg.sv
// rvh_noc_pkg
// Shared NoC types and widths for the router, the couple module and the
// local injection buffer.
//   io_port_t            : router output port selected by look-ahead routing
//   local_inject_entry_t : one buffered injection flit (payload, target, QoS)
package rvh_noc_pkg;

   localparam int NodeID_X_Width         = 2;
   localparam int NodeID_Y_Width         = 2;
   localparam int QoS_Value_Width        = 4;
   localparam int VC_ID_NUM_MAX_W        = 2;
   localparam int LOCAL_INJECT_PAYLOAD_W = 64;

   typedef enum logic [2:0] {
      N = 3'd0,
      S = 3'd1,
      E = 3'd2,
      W = 3'd3,
      L = 3'd4
   } io_port_t;

   typedef struct packed {
      logic [LOCAL_INJECT_PAYLOAD_W-1:0] payload;
      logic [NodeID_X_Width-1:0]         tgt_x;
      logic [NodeID_Y_Width-1:0]         tgt_y;
      logic [QoS_Value_Width-1:0]        qos;
   } local_inject_entry_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo
// Single-clock FIFO with registered pointers and occupancy count. The head
// entry is presented combinationally; there is no write-to-read bypass, so a
// pushed entry becomes visible at the head one cycle after the push edge.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (storage not reset)
//   push, pop    : qualified enqueue / dequeue strobes (callers gate them)
//   wdata, rdata : entry written on push / entry at the head
//   count        : current number of entries
//   full, empty  : count == DEPTH / count == 0
module noc_sync_fifo
   import rvh_noc_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = local_inject_entry_t,
   parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  entry_t           wdata,
   output entry_t           rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   // Storage is deliberately left out of reset; the count guards it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and count; simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Overflow and underflow guards; these only fire if a caller ignores
   // full/empty.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && !pop && full));
         assert (!(pop && empty));
         assert (count <= CNT_W'(DEPTH));
      end
   end

endmodule

// File: rtl/local_port_inject_buffer.sv
// local_port_inject_buffer
// Injection-side flit buffer between a local device and its couple module.
// Device flits are queued in order; the head's target and QoS are offered to
// the couple module, and a credit grant dequeues the head into a registered
// output stage toward the router local input port, tagged with the granted
// VC and the look-ahead routing result from the grant cycle.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   dev_flit_*, dev_tgt_*, dev_qos_i : device-side valid/ready enqueue
//   head_*                       : head flit status toward the couple module
//   free_credit_*, look_ahead_routing_i : couple grant, VC and routing
//   rx_flit_*                    : registered flit toward the router
//   occupancy_o                  : current FIFO entry count
module local_port_inject_buffer
   import rvh_noc_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int FLIT_PAYLOAD_W = 64,
   parameter int CNT_W          = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       dev_flit_v_i,
   output logic                       dev_flit_rdy_o,
   input  logic [FLIT_PAYLOAD_W-1:0]  dev_flit_payload_i,
   input  logic [NodeID_X_Width-1:0]  dev_tgt_x_i,
   input  logic [NodeID_Y_Width-1:0]  dev_tgt_y_i,
   input  logic [QoS_Value_Width-1:0] dev_qos_i,
   output logic                       head_vld_o,
   output logic [NodeID_X_Width-1:0]  head_tgt_x_o,
   output logic [NodeID_Y_Width-1:0]  head_tgt_y_o,
   output logic [QoS_Value_Width-1:0] head_qos_o,
   input  logic                       free_credit_vld_i,
   input  logic [VC_ID_NUM_MAX_W-1:0] free_credit_vc_id_i,
   input  io_port_t                   look_ahead_routing_i,
   output logic                       rx_flit_v_o,
   output logic [FLIT_PAYLOAD_W-1:0]  rx_flit_payload_o,
   output logic [NodeID_X_Width-1:0]  rx_flit_tgt_x_o,
   output logic [NodeID_Y_Width-1:0]  rx_flit_tgt_y_o,
   output logic [QoS_Value_Width-1:0] rx_flit_qos_o,
   output logic [VC_ID_NUM_MAX_W-1:0] rx_flit_vc_id_o,
   output io_port_t                   rx_flit_look_ahead_routing_o,
   output logic [CNT_W-1:0]           occupancy_o
);

   // Same layout as local_inject_entry_t, but sized by this instance's payload.
   typedef struct packed {
      logic [FLIT_PAYLOAD_W-1:0]  payload;
      logic [NodeID_X_Width-1:0]  tgt_x;
      logic [NodeID_Y_Width-1:0]  tgt_y;
      logic [QoS_Value_Width-1:0] qos;
   } entry_t;

   entry_t wr_entry;
   entry_t head_entry;
   logic   enq;
   logic   deq;
   logic   full;
   logic   empty;

   // Ready depends only on registered occupancy, never on the credit input.
   assign dev_flit_rdy_o = !full;
   assign head_vld_o     = !empty;
   assign enq            = dev_flit_v_i && dev_flit_rdy_o;
   assign deq            = head_vld_o && free_credit_vld_i;

   assign wr_entry.payload = dev_flit_payload_i;
   assign wr_entry.tgt_x   = dev_tgt_x_i;
   assign wr_entry.tgt_y   = dev_tgt_y_i;
   assign wr_entry.qos     = dev_qos_i;

   assign head_tgt_x_o = head_entry.tgt_x;
   assign head_tgt_y_o = head_entry.tgt_y;
   assign head_qos_o   = head_entry.qos;

   noc_sync_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t),
      .CNT_W   (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (enq),
      .pop   (deq),
      .wdata (wr_entry),
      .rdata (head_entry),
      .count (occupancy_o),
      .full  (full),
      .empty (empty)
   );

   // Output stage has no backpressure: a credit already reserves a router
   // slot. Fields hold their last value when no flit is dequeued.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_flit_v_o                  <= 1'b0;
         rx_flit_payload_o            <= '0;
         rx_flit_tgt_x_o              <= '0;
         rx_flit_tgt_y_o              <= '0;
         rx_flit_qos_o                <= '0;
         rx_flit_vc_id_o              <= '0;
         rx_flit_look_ahead_routing_o <= io_port_t'(3'd0);
      end else begin
         rx_flit_v_o <= deq;
         if (deq) begin
            rx_flit_payload_o            <= head_entry.payload;
            rx_flit_tgt_x_o              <= head_entry.tgt_x;
            rx_flit_tgt_y_o              <= head_entry.tgt_y;
            rx_flit_qos_o                <= head_entry.qos;
            rx_flit_vc_id_o              <= free_credit_vc_id_i;
            rx_flit_look_ahead_routing_o <= look_ahead_routing_i;
         end
      end
   end

endmodule

// File: tb/tb_local_port_inject_buffer.sv
// tb_local_port_inject_buffer
// Directed testbench for local_port_inject_buffer (DEPTH=4).
module tb_local_port_inject_buffer;
   import rvh_noc_pkg::*;

   localparam int DEPTH = 4;
   localparam int PW    = 64;
   localparam int CW    = $clog2(DEPTH + 1);

   logic                       clk;
   logic                       rst;
   logic                       dev_flit_v;
   logic                       dev_flit_rdy;
   logic [PW-1:0]              dev_flit_payload;
   logic [NodeID_X_Width-1:0]  dev_tgt_x;
   logic [NodeID_Y_Width-1:0]  dev_tgt_y;
   logic [QoS_Value_Width-1:0] dev_qos;
   logic                       head_vld;
   logic [NodeID_X_Width-1:0]  head_tgt_x;
   logic [NodeID_Y_Width-1:0]  head_tgt_y;
   logic [QoS_Value_Width-1:0] head_qos;
   logic                       grant;
   logic [VC_ID_NUM_MAX_W-1:0] grant_vc;
   io_port_t                   route;
   logic                       rx_v;
   logic [PW-1:0]              rx_payload;
   logic [NodeID_X_Width-1:0]  rx_tgt_x;
   logic [NodeID_Y_Width-1:0]  rx_tgt_y;
   logic [QoS_Value_Width-1:0] rx_qos;
   logic [VC_ID_NUM_MAX_W-1:0] rx_vc;
   io_port_t                   rx_route;
   logic [CW-1:0]              occupancy;

   int checks   = 0;
   int failures = 0;
   int rx_count = 0;

   local_port_inject_buffer #(
      .DEPTH          (DEPTH),
      .FLIT_PAYLOAD_W (PW)
   ) dut (
      .clk                          (clk),
      .rst                          (rst),
      .dev_flit_v_i                 (dev_flit_v),
      .dev_flit_rdy_o               (dev_flit_rdy),
      .dev_flit_payload_i           (dev_flit_payload),
      .dev_tgt_x_i                  (dev_tgt_x),
      .dev_tgt_y_i                  (dev_tgt_y),
      .dev_qos_i                    (dev_qos),
      .head_vld_o                   (head_vld),
      .head_tgt_x_o                 (head_tgt_x),
      .head_tgt_y_o                 (head_tgt_y),
      .head_qos_o                   (head_qos),
      .free_credit_vld_i            (grant),
      .free_credit_vc_id_i          (grant_vc),
      .look_ahead_routing_i         (route),
      .rx_flit_v_o                  (rx_v),
      .rx_flit_payload_o            (rx_payload),
      .rx_flit_tgt_x_o              (rx_tgt_x),
      .rx_flit_tgt_y_o              (rx_tgt_y),
      .rx_flit_qos_o                (rx_qos),
      .rx_flit_vc_id_o              (rx_vc),
      .rx_flit_look_ahead_routing_o (rx_route),
      .occupancy_o                  (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle 1 time unit past the edge before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the device side and the couple-module grant side together.
   task automatic applyStimulus(input logic v, input logic [PW-1:0] pl,
                                input logic [NodeID_X_Width-1:0] x,
                                input logic [NodeID_Y_Width-1:0] y,
                                input logic [QoS_Value_Width-1:0] q,
                                input logic g, input logic [VC_ID_NUM_MAX_W-1:0] vc,
                                input io_port_t r);
      dev_flit_v       = v;
      dev_flit_payload = pl;
      dev_tgt_x        = x;
      dev_tgt_y        = y;
      dev_qos          = q;
      grant            = g;
      grant_vc         = vc;
      route            = r;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      $display("[TB] local_port_inject_buffer directed test start");
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, N);
      tick();
      tick();

      // Reset state
      checkOutput("reset_rdy", 64'(dev_flit_rdy), 64'd1);
      checkOutput("reset_head_vld", 64'(head_vld), 64'd0);
      checkOutput("reset_rx_v", 64'(rx_v), 64'd0);
      checkOutput("reset_occ", 64'(occupancy), 64'd0);
      checkOutput("reset_rx_payload", rx_payload, 64'd0);
      rst = 1'b0;

      // Single flit with grant held high: head next cycle, rx the cycle after
      applyStimulus(1'b1, 64'hA1, 2'd2, 2'd1, 4'd0, 1'b1, 2'd3, E);
      tick();
      dev_flit_v = 1'b0;
      checkOutput("single_head_vld", 64'(head_vld), 64'd1);
      checkOutput("single_head_x", 64'(head_tgt_x), 64'd2);
      checkOutput("single_head_y", 64'(head_tgt_y), 64'd1);
      checkOutput("single_no_bypass", 64'(rx_v), 64'd0);
      tick();
      checkOutput("single_rx_v", 64'(rx_v), 64'd1);
      checkOutput("single_rx_payload", rx_payload, 64'hA1);
      checkOutput("single_rx_vc", 64'(rx_vc), 64'd3);
      checkOutput("single_rx_route", 64'(rx_route), 64'(E));
      checkOutput("single_rx_x", 64'(rx_tgt_x), 64'd2);
      checkOutput("single_rx_y", 64'(rx_tgt_y), 64'd1);
      checkOutput("single_occ", 64'(occupancy), 64'd0);
      grant = 1'b0;
      tick();
      checkOutput("single_rx_drop", 64'(rx_v), 64'd0);
      checkOutput("single_rx_hold", rx_payload, 64'hA1);

      // Fill to DEPTH with grant low, then offer a fifth flit
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 64'hB0 + 64'(i), 2'(i), 2'(3 - i), 4'(i + 1), 1'b0, '0, N);
         tick();
      end
      checkOutput("full_occ", 64'(occupancy), 64'd4);
      checkOutput("full_rdy", 64'(dev_flit_rdy), 64'd0);
      applyStimulus(1'b1, 64'hB4, 2'd0, 2'd0, 4'd9, 1'b0, '0, N);
      tick();
      checkOutput("full_reject_occ", 64'(occupancy), 64'd4);
      checkOutput("full_head_qos", 64'(head_qos), 64'd1);
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 2'd1, N);
      tick();
      checkOutput("full_deq_occ", 64'(occupancy), 64'd3);
      checkOutput("full_deq_rdy", 64'(dev_flit_rdy), 64'd1);
      checkOutput("full_deq_payload", rx_payload, 64'hB0);
      checkOutput("full_deq_qos", 64'(rx_qos), 64'd1);

      // Grant toggling 1,0,1,0 with three flits buffered
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 2'd2, S);
      tick();
      checkOutput("tog1_v", 64'(rx_v), 64'd1);
      checkOutput("tog1_payload", rx_payload, 64'hB1);
      checkOutput("tog1_vc", 64'(rx_vc), 64'd2);
      checkOutput("tog1_route", 64'(rx_route), 64'(S));
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, 2'd0, W);
      tick();
      checkOutput("tog2_v", 64'(rx_v), 64'd0);
      checkOutput("tog2_vc_hold", 64'(rx_vc), 64'd2);
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 2'd1, W);
      tick();
      checkOutput("tog3_v", 64'(rx_v), 64'd1);
      checkOutput("tog3_payload", rx_payload, 64'hB2);
      checkOutput("tog3_vc", 64'(rx_vc), 64'd1);
      checkOutput("tog3_route", 64'(rx_route), 64'(W));
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, 2'd3, N);
      tick();
      checkOutput("tog4_v", 64'(rx_v), 64'd0);
      checkOutput("tog4_occ", 64'(occupancy), 64'd1);
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 2'd0, L);
      tick();
      checkOutput("drain_payload", rx_payload, 64'hB3);
      checkOutput("drain_route", 64'(rx_route), 64'(L));
      checkOutput("drain_head_vld", 64'(head_vld), 64'd0);

      // Continuous enqueue and grant for 10 cycles; pointers wrap
      rx_count = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 64'hC0 + 64'(i), 2'(i), 2'(i), 4'(i), 1'b1, 2'(i), N);
         tick();
         if (rx_v) rx_count++;
         if (i >= 1) begin
            checkOutput("stream_payload", rx_payload, 64'hC0 + 64'(i - 1));
            checkOutput("stream_occ", 64'(occupancy), 64'd1);
         end
      end
      dev_flit_v = 1'b0;
      tick();
      if (rx_v) rx_count++;
      checkOutput("stream_last_payload", rx_payload, 64'hC9);
      checkOutput("stream_last_vc", 64'(rx_vc), 64'd1);
      tick();
      checkOutput("stream_end_v", 64'(rx_v), 64'd0);
      checkOutput("stream_count", 64'(rx_count), 64'd10);

      // Grant while empty is ignored
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 2'd2, E);
      tick();
      tick();
      checkOutput("empty_grant_v", 64'(rx_v), 64'd0);
      checkOutput("empty_grant_occ", 64'(occupancy), 64'd0);
      checkOutput("empty_grant_hold", rx_payload, 64'hC9);

      // Reset with flits buffered and an rx flit in flight
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 64'hD0 + 64'(i), 2'd1, 2'd1, 4'd2, 1'b0, '0, N);
         tick();
      end
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 2'd3, S);
      tick();
      checkOutput("prerst_rx_v", 64'(rx_v), 64'd1);
      checkOutput("prerst_payload", rx_payload, 64'hD0);
      checkOutput("prerst_occ", 64'(occupancy), 64'd2);
      grant = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_occ", 64'(occupancy), 64'd0);
      checkOutput("rst_rx_v", 64'(rx_v), 64'd0);
      checkOutput("rst_rdy", 64'(dev_flit_rdy), 64'd1);
      checkOutput("rst_payload", rx_payload, 64'd0);
      checkOutput("rst_vc", 64'(rx_vc), 64'd0);

      // Operation resumes cleanly after reset
      applyStimulus(1'b1, 64'hE0, 2'd3, 2'd2, 4'd5, 1'b1, 2'd1, W);
      tick();
      dev_flit_v = 1'b0;
      tick();
      checkOutput("post_rst_v", 64'(rx_v), 64'd1);
      checkOutput("post_rst_payload", rx_payload, 64'hE0);
      checkOutput("post_rst_qos", 64'(rx_qos), 64'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
